// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured frame out MSB first, one bit per bit_en tick,
// repeating the frame back-to-back a programmable number of times.
module serial_pattern_tx #(
  parameter int   MAX_LEN    = 16,
  parameter int   LEN_W      = 5,
  parameter int   CNT_W      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   repeat_cnt,
  input  logic               bit_en,
  output logic               x,
  output logic               x_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [MAX_LEN-1:0] pat_r, pat_s;
  logic [LEN_W-1:0]   top_r, top_s;
  logic [LEN_W-1:0]   idx_r, idx_s;
  logic [LEN_W-1:0]   eff_len_s;
  logic [CNT_W-1:0]   frm_r, frm_s;
  logic               x_r, x_s;
  logic               xv_r, xv_s;
  logic               fs_r, fs_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  assign x           = x_r;
  assign x_valid     = xv_r;
  assign frame_start = fs_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Next-state and next-output logic for the transmit FSM
  always_comb begin
    state_s = state_r;
    pat_s   = pat_r;
    top_s   = top_r;
    idx_s   = idx_r;
    frm_s   = frm_r;
    x_s     = x_r;
    xv_s    = 1'b0;
    fs_s    = 1'b0;
    busy_s  = busy_r;
    done_s  = 1'b0;
    eff_len_s = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

    case (state_r)
      IDLE: begin
        x_s    = IDLE_LEVEL;
        busy_s = 1'b0;
        // The done cycle still counts as finishing, so a start there is dropped
        if (start && !done_r) begin
          pat_s  = pattern;
          top_s  = eff_len_s - LEN_W'(1);
          idx_s  = eff_len_s - LEN_W'(1);
          frm_s  = repeat_cnt;
          busy_s = 1'b1;
          if ((eff_len_s == LEN_W'(0)) || (repeat_cnt == CNT_W'(0))) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_s = IDLE;
          x_s     = IDLE_LEVEL;
          busy_s  = 1'b0;
        end else if (bit_en) begin
          x_s  = pat_r[idx_r[IDX_W-1:0]];
          xv_s = 1'b1;
          fs_s = (idx_r == top_r);
          if (idx_r == LEN_W'(0)) begin
            if (frm_r > CNT_W'(1)) begin
              frm_s = frm_r - CNT_W'(1);
              idx_s = top_r;
            end else begin
              state_s = DONE;
            end
          end else begin
            idx_s = idx_r - LEN_W'(1);
          end
        end else begin
          x_s = x_r;
        end
      end
      DONE: begin
        state_s = IDLE;
        done_s  = 1'b1;
        busy_s  = 1'b0;
        x_s     = IDLE_LEVEL;
      end
      default: begin
        state_s = IDLE;
        x_s     = IDLE_LEVEL;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, captured frame and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      pat_r   <= '0;
      top_r   <= '0;
      idx_r   <= '0;
      frm_r   <= '0;
      x_r     <= IDLE_LEVEL;
      xv_r    <= 1'b0;
      fs_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pat_r   <= pat_s;
      top_r   <= top_s;
      idx_r   <= idx_s;
      frm_r   <= frm_s;
      x_r     <= x_s;
      xv_r    <= xv_s;
      fs_r    <= fs_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

endmodule
